// File: rtl/add_pipe_pkg.sv
// add_pipe_pkg: shared constants, stage-count helper and per-stage flag payload
// for the pipelined adder. Optional macro ADD_PIPE_OVF_EN adds operand MSBs to
// the payload so the signed-overflow flag can be produced at the output.
package add_pipe_pkg;

  localparam int unsigned ADD_PIPE_WIDTH_DEF = 32;
  localparam int unsigned ADD_PIPE_CHUNK_DEF = 8;

  // Number of register stages: one CHUNK-bit carry slice per stage.
  function automatic int unsigned add_pipe_stages(input int unsigned width,
                                                  input int unsigned chunk);
    return width / chunk;
  endfunction

  // Width-independent part of a stage payload. The WIDTH-sized fields
  // (partial sum, remaining operand slices) live beside it in add_pipe
  // because they depend on the instance parameters.
  typedef struct packed {
    logic carry;
`ifdef ADD_PIPE_OVF_EN
    logic a_msb;
    logic b_msb;
`endif
  } add_pipe_flags_t;

endpackage

// File: rtl/add_pipe_slice.sv
// add_pipe_slice: combinational CHUNK-bit adder with carry in and carry out.
// One instance per pipeline stage of add_pipe.
module add_pipe_slice
  import add_pipe_pkg::*;
#(
  parameter int unsigned CHUNK = ADD_PIPE_CHUNK_DEF
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             c_in,
  output logic [CHUNK-1:0] sum,
  output logic             c_out
);

  logic [CHUNK:0] full;

  assign full  = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, c_in};
  assign sum   = full[CHUNK-1:0];
  assign c_out = full[CHUNK];

endmodule

// File: rtl/add_pipe.sv
// add_pipe: pipelined WIDTH-bit adder, {c_out, sum} = a + b + c_in, with the
// carry chain split into CHUNK-bit slices, one slice per register stage.
// valid/ready on both sides with full backpressure; one result per clock when
// unstalled. Optional macro ADD_PIPE_OVF_EN adds the signed-overflow output ovf.
module add_pipe
  import add_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = ADD_PIPE_WIDTH_DEF,
  parameter int unsigned CHUNK = ADD_PIPE_CHUNK_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
`ifdef ADD_PIPE_OVF_EN
  output logic             ovf,
`endif
  output logic             c_out
);

  localparam int unsigned STAGES = add_pipe_stages(WIDTH, CHUNK);

  // Stage registers. a_q/b_q hold the not-yet-added operand slices shifted
  // down so the next slice always sits at [CHUNK-1:0]; psum_q holds the
  // accumulated low sum bits (bits above the accumulated part stay zero).
  logic [STAGES-1:0] v_q;
  logic [WIDTH-1:0]  psum_q [STAGES];
  logic [WIDTH-1:0]  a_q    [STAGES];
  logic [WIDTH-1:0]  b_q    [STAGES];
  add_pipe_flags_t   flg_q  [STAGES];

  // Per-stage inputs (from the ports for stage 0, from stage k-1 otherwise).
  logic [STAGES-1:0] v_src;
  logic [WIDTH-1:0]  psum_src  [STAGES];
  logic [WIDTH-1:0]  a_src     [STAGES];
  logic [WIDTH-1:0]  b_src     [STAGES];
  logic              carry_src [STAGES];
`ifdef ADD_PIPE_OVF_EN
  logic              a_msb_src [STAGES];
  logic              b_msb_src [STAGES];
`endif

  // Per-stage results of this cycle's slice add.
  logic [CHUNK-1:0]  slice_sum [STAGES];
  logic              slice_co  [STAGES];
  logic [WIDTH-1:0]  psum_nxt  [STAGES];
  add_pipe_flags_t   flg_nxt   [STAGES];

  logic [STAGES-1:0] adv;

  // Route each stage's inputs: ports feed stage 0, stage k-1 feeds stage k.
  always_comb begin
    v_src        = '0;
    v_src[0]     = in_valid;
    a_src[0]     = a;
    b_src[0]     = b;
    psum_src[0]  = '0;
    carry_src[0] = c_in;
`ifdef ADD_PIPE_OVF_EN
    a_msb_src[0] = a[WIDTH-1];
    b_msb_src[0] = b[WIDTH-1];
`endif
    for (int unsigned i = 1; i < STAGES; i++) begin
      v_src[i]     = v_q[i-1];
      a_src[i]     = a_q[i-1];
      b_src[i]     = b_q[i-1];
      psum_src[i]  = psum_q[i-1];
      carry_src[i] = flg_q[i-1].carry;
`ifdef ADD_PIPE_OVF_EN
      a_msb_src[i] = flg_q[i-1].a_msb;
      b_msb_src[i] = flg_q[i-1].b_msb;
`endif
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    add_pipe_slice #(
      .CHUNK (CHUNK)
    ) u_slice (
      .a     (a_src[k][CHUNK-1:0]),
      .b     (b_src[k][CHUNK-1:0]),
      .c_in  (carry_src[k]),
      .sum   (slice_sum[k]),
      .c_out (slice_co[k])
    );
  end

  // Merge each slice result into the partial sum at its bit position.
  always_comb begin
    for (int unsigned i = 0; i < STAGES; i++) begin
      psum_nxt[i]       = psum_src[i] | (WIDTH'(slice_sum[i]) << (i * CHUNK));
      flg_nxt[i]        = '0;
      flg_nxt[i].carry  = slice_co[i];
`ifdef ADD_PIPE_OVF_EN
      flg_nxt[i].a_msb  = a_msb_src[i];
      flg_nxt[i].b_msb  = b_msb_src[i];
`endif
    end
  end

  // Stall chain. The recursive form adv[k] = !v[k] || adv[k+1] is unrolled
  // into "some stage from k to the end is empty, or the consumer is ready",
  // which is the same function without a self-referencing vector.
  always_comb begin
    adv = '0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      logic full_run;
      full_run = 1'b1;
      for (int unsigned j = i; j < STAGES; j++) begin
        full_run = full_run & v_q[j];
      end
      adv[i] = !full_run || out_ready;
    end
  end

  // Stage registers: advance when allowed, load payload only with valid data.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      for (int unsigned i = 0; i < STAGES; i++) begin
        psum_q[i] <= '0;
        a_q[i]    <= '0;
        b_q[i]    <= '0;
        flg_q[i]  <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        if (adv[i]) begin
          v_q[i] <= v_src[i];
          if (v_src[i]) begin
            psum_q[i] <= psum_nxt[i];
            a_q[i]    <= a_src[i] >> CHUNK;
            b_q[i]    <= b_src[i] >> CHUNK;
            flg_q[i]  <= flg_nxt[i];
          end
        end
      end
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = v_q[STAGES-1];
  assign sum       = psum_q[STAGES-1];
  assign c_out     = flg_q[STAGES-1].carry;

`ifdef ADD_PIPE_OVF_EN
  assign ovf = (flg_q[STAGES-1].a_msb == flg_q[STAGES-1].b_msb) &&
               (psum_q[STAGES-1][WIDTH-1] != flg_q[STAGES-1].a_msb);
`endif

endmodule

// File: tb/tb_add_pipe.sv
// tb_add_pipe: directed and randomized stimulus for add_pipe (WIDTH=32,
// CHUNK=8), checked against an arithmetic reference queue.
module tb_add_pipe;

  localparam int unsigned W   = 32;
  localparam int unsigned C   = 8;
  localparam int unsigned STG = W / C;

  logic         clk       = 1'b0;
  logic         rst       = 1'b1;
  logic         in_valid  = 1'b0;
  logic         out_ready = 1'b0;
  logic         c_in      = 1'b0;
  logic [W-1:0] a         = '0;
  logic [W-1:0] b         = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] sum;
  logic         c_out;
`ifdef ADD_PIPE_OVF_EN
  logic         ovf;
`endif

  add_pipe #(
    .WIDTH (W),
    .CHUNK (C)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
`ifdef ADD_PIPE_OVF_EN
    .ovf       (ovf),
`endif
    .c_out     (c_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] sum;
    logic         co;
    logic         ov;
    int           acc_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   n_emit   = 0;
  bit   lat_chk  = 1'b0;
  bit   last_acc = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    logic [W:0] t;
    exp_t e;
    t = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    e.sum     = t[W-1:0];
    e.co      = t[W];
    e.ov      = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
    e.acc_cyc = cyc;
    return e;
  endfunction

  // One clock: sample handshakes at negedge, score emissions, log accepts.
  task automatic step();
    exp_t e;
    @(negedge clk);
    cyc++;
    last_acc = 1'b0;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_emit++;
        if (exp_q.size() == 0) begin
          check("spurious_out_valid", out_valid, 0);
        end else begin
          e = exp_q.pop_front();
          check("sum", sum, e.sum);
          check("c_out", c_out, e.co);
`ifdef ADD_PIPE_OVF_EN
          check("ovf", ovf, e.ov);
`endif
          if (lat_chk) check("latency", cyc - e.acc_cyc, STG);
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, c_in));
        last_acc = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                      output int tries);
    a        = x;
    b        = y;
    c_in     = ci;
    in_valid = 1'b1;
    tries    = 0;
    while (tries < 50) begin
      step();
      tries++;
      if (last_acc) break;
    end
    if (!last_acc) check("send_accept_timeout", last_acc, 1);
  endtask

  task automatic drain(input int bound);
    in_valid = 1'b0;
    for (int n = 0; n < bound && exp_q.size() > 0; n++) step();
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] oa [8];
    logic [W-1:0] ob [8];
    logic         oc [8];
    int           idx;
    int           tries;
    int           emit0;

    // Reset held 3 cycles with in_valid asserted: nothing accepted.
    rst      = 1'b1;
    in_valid = 1'b1;
    a        = $urandom;
    b        = $urandom;
    c_in     = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      a = $urandom;
      b = $urandom;
      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_sum", sum, 0);
      check("rst_c_out", c_out, 0);
      check("rst_in_ready", in_ready, 1);
`ifdef ADD_PIPE_OVF_EN
      check("rst_ovf", ovf, 0);
`endif
      @(posedge clk);
      #1;
    end
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < STG + 2; i++) begin
      @(negedge clk);
      check("post_rst_idle_out_valid", out_valid, 0);
      @(posedge clk);
      #1;
    end

    // Latency and value of a single small add.
    lat_chk = 1'b1;
    emit0   = n_emit;
    send(32'h0000_00FF, 32'h0000_0001, 1'b0, tries);
    drain(20);
    check("latency_emits", n_emit - emit0, 1);

    // Carry ripples through every slice.
    send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, tries);
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, tries);
    drain(20);

    // Backpressure: fill with out_ready=0, then toggle out_ready.
    lat_chk   = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      oa[i] = $urandom;
      ob[i] = $urandom;
      oc[i] = 1'($urandom_range(1));
    end
    idx   = 0;
    emit0 = n_emit;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      a        = oa[idx];
      b        = ob[idx];
      c_in     = oc[idx];
      step();
      if (last_acc) idx++;
    end
    check("bp_accepts_when_full", idx, STG);
    check("bp_in_ready_full", in_ready, 0);
    check("bp_no_emit_while_stalled", n_emit - emit0, 0);
    for (int i = 0; i < 200 && (idx < 8 || exp_q.size() > 0); i++) begin
      out_ready = (i % 2 == 0);
      in_valid  = (idx < 8);
      if (idx < 8) begin
        a    = oa[idx];
        b    = ob[idx];
        c_in = oc[idx];
      end
      step();
      if (last_acc) idx++;
    end
    check("bp_all_accepted", idx, 8);
    check("bp_all_emitted", n_emit - emit0, 8);
    check("bp_queue_empty", exp_q.size(), 0);

    // Random traffic with random gaps and random consumer stalls.
    in_valid = 1'b0;
    for (int i = 0; i < 120; i++) begin
      if (!in_valid || last_acc) begin
        in_valid = ($urandom_range(3) != 0);
        a        = $urandom;
        b        = $urandom;
        c_in     = 1'($urandom_range(1));
      end
      out_ready = ($urandom_range(2) != 0);
      step();
    end
    out_ready = 1'b1;
    drain(40);

    // Reset with three operands in flight: none of them may emerge.
    lat_chk = 1'b1;
    for (int i = 0; i < 3; i++) send($urandom, $urandom, 1'($urandom_range(1)), tries);
    in_valid = 1'b0;
    rst      = 1'b1;
    step();
    rst   = 1'b0;
    emit0 = n_emit;
    send(32'h1234_5678, 32'h0FED_CBA9, 1'b1, tries);
    check("post_rst_first_cycle_accept", tries, 1);
    in_valid = 1'b0;
    for (int i = 0; i < STG + 4; i++) step();
    check("post_rst_emit_count", n_emit - emit0, 1);
    check("post_rst_queue_empty", exp_q.size(), 0);

`ifdef ADD_PIPE_OVF_EN
    // Signed overflow cases.
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, tries);
    send(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, tries);
    send(32'h0000_0005, 32'h0000_0003, 1'b0, tries);
    drain(20);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
